fetch_seq: RTL and testbench

//  Fetch/decode sequencer for the 4-bit core; sits directly upstream of the instruction register.

---
 rtl/fetch_seq_pkg.sv | 30 +++
 rtl/fetch_seq_pc_counter.sv | 29 ++
 rtl/fetch_seq.sv | 109 ++++++++++
 tb/tb_fetch_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch/decode sequencer: opcodes, ALU codes, FSM states.
// The PAUSE state is only reachable when FETCH_SEQ_SINGLE_STEP_EN is defined.
package fetch_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_HALT    = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  // Instructions carrying a second word (immediate or jump target).
  function automatic logic two_word(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_JZ);
  endfunction

endpackage

// File: rtl/fetch_seq_pc_counter.sv
// Program counter register: synchronous reset to RESET_VECTOR, load has priority over increment.
// Wraps silently modulo 2^ADDR_W.
module pc_counter #(
  parameter int ADDR_W       = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_loadVal,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= ADDR_W'(RESET_VECTOR);
    end else if (i_load) begin
      r_pc <= i_loadVal;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_seq.sv
// Fetch/decode sequencer for the 4-bit core: owns the PC, pulses IR load, sequences two-word instructions.
// Optional FETCH_SEQ_SINGLE_STEP_EN adds a `step` input and a PAUSE state after each instruction.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic              reg_clk,
  input  logic              reg_rst,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              run,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] ir_q,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              ir_en,
  output logic              acc_en,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] operand,
  output logic              halted
);

  state_t      r_state;
  logic        w_opLegal;
  logic [3:0]  w_op;
  logic        w_isAlu;
  logic        w_isJmp;
  logic        w_isJz;
  logic        w_isHlt;
  logic        w_twoWord;
  logic        w_inOperand;
  logic        w_pcLoad;
  logic        w_pcInc;
  state_t      w_afterExec;

  // Opcode is the whole word; any set bit above the low nibble makes it an undefined (NOP) opcode.
  assign w_opLegal   = ((ir_q >> 4) == '0);
  assign w_op        = w_opLegal ? ir_q[3:0] : OP_NOP;
  assign w_isAlu     = (w_op == OP_LDI) || (w_op == OP_ADD) || (w_op == OP_SUB);
  assign w_isJmp     = (w_op == OP_JMP);
  assign w_isJz      = (w_op == OP_JZ);
  assign w_isHlt     = (w_op == OP_HLT);
  assign w_twoWord   = two_word(w_op);

  assign w_inOperand = (r_state == ST_OPERAND) && !reg_rst;
  assign w_pcLoad    = w_inOperand && (w_isJmp || (w_isJz && zero_flag));
  assign w_pcInc     = !reg_rst && (((r_state == ST_FETCH) && run) || (r_state == ST_OPERAND));

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  assign w_afterExec = ST_PAUSE;
`else
  assign w_afterExec = ST_FETCH;
`endif

  pc_counter #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .i_clk     (reg_clk),
    .i_rst     (reg_rst),
    .i_inc     (w_pcInc),
    .i_load    (w_pcLoad),
    .i_loadVal (mem_data[ADDR_W-1:0]),
    .o_pc      (pc_addr)
  );

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      r_state <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH:   if (run) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_isHlt)        r_state <= ST_HALT;
          else if (w_twoWord) r_state <= ST_OPERAND;
          else                r_state <= w_afterExec;
        end
        ST_OPERAND: r_state <= w_afterExec;
        ST_HALT:    r_state <= ST_HALT;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        ST_PAUSE:   if (step) r_state <= ST_FETCH;
`endif
        default:    r_state <= ST_FETCH;
      endcase
    end
  end

  // Outputs decode the state register; reset suppresses every strobe in the cycle it is asserted.
  assign ir_en   = !reg_rst && (r_state == ST_FETCH) && run;
  assign acc_en  = w_inOperand && w_isAlu;
  assign operand = acc_en ? mem_data : '0;
  assign halted  = !reg_rst && (r_state == ST_HALT);

  always_comb begin
    alu_op = ALU_PASS;
    if (acc_en) begin
      case (w_op)
        OP_ADD:  alu_op = ALU_ADD;
        OP_SUB:  alu_op = ALU_SUB;
        default: alu_op = ALU_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: ROM and IR are modelled here; accumulator strobes go through a scoreboard.
// Expectations target the default build (FETCH_SEQ_SINGLE_STEP_EN undefined).
module tb_fetch_seq;

  typedef struct {
    int         cyc;
    logic [1:0] op;
    logic [3:0] opd;
  } strobe_t;

  logic       clk = 1'b0;
  logic       regRst = 1'b1;
  logic       run = 1'b0;
  logic       zeroFlag = 1'b0;
  logic [3:0] rom [16];
  logic [3:0] romData;
  logic [3:0] irQ = 4'h0;
  logic [3:0] pcAddr;
  logic       irEn;
  logic       accEn;
  logic [1:0] aluOp;
  logic [3:0] operand;
  logic       halted;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  int      total = 0;
  int      bad = 0;
  int      cycleCnt = 0;
  int      base = 0;
  strobe_t expQ[$];
  strobe_t obsQ[$];

  fetch_seq dut (
    .reg_clk   (clk),
    .reg_rst   (regRst),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .run       (run),
    .mem_data  (romData),
    .ir_q      (irQ),
    .zero_flag (zeroFlag),
    .pc_addr   (pcAddr),
    .ir_en     (irEn),
    .acc_en    (accEn),
    .alu_op    (aluOp),
    .operand   (operand),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // ROM read is combinational; IR is an ordinary enable register.
  assign romData = rom[pcAddr];

  always @(posedge clk) begin
    if (irEn) irQ <= romData;
    cycleCnt <= cycleCnt + 1;
  end

  // Record every accumulator strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (accEn) obsQ.push_back('{cycleCnt, aluOp, operand});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic loadRom(input logic [63:0] img);
    for (int i = 0; i < 16; i++) rom[i] = img[63-4*i -: 4];
  endtask

  // Leaves the bench 1 ns into cycle 1 (first cycle with reset released).
  task automatic doReset();
    regRst = 1'b1;
    tick();
    tick();
    regRst = 1'b0;
    base = cycleCnt;
    obsQ.delete();
    expQ.delete();
    #1;
  endtask

  task automatic test_reset();
    loadRom(64'h1700_0000_0000_0000);
    run = 1'b1;
    regRst = 1'b1;
    tick();
    tick();
    total++; if (irEn !== 1'b0) begin bad++; $display("[TB] FAIL rst_ir_en: got %b want 0", irEn); end
    total++; if (pcAddr !== 4'h0) begin bad++; $display("[TB] FAIL rst_pc: got %h want 0", pcAddr); end
    total++; if (accEn !== 1'b0) begin bad++; $display("[TB] FAIL rst_acc_en: got %b want 0", accEn); end
    total++; if (aluOp !== 2'b00) begin bad++; $display("[TB] FAIL rst_alu_op: got %b want 00", aluOp); end
    total++; if (operand !== 4'h0) begin bad++; $display("[TB] FAIL rst_operand: got %h want 0", operand); end
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL rst_halted: got %b want 0", halted); end
  endtask

  task automatic test_alu();
    // LDI 7; ADD 3; SUB 5; HLT
    loadRom(64'h1723_35F0_0000_0000);
    run = 1'b1;
    doReset();
    expQ.push_back('{base + 2, 2'b00, 4'h7});
    expQ.push_back('{base + 5, 2'b01, 4'h3});
    expQ.push_back('{base + 8, 2'b10, 4'h5});
    total++; if (irEn !== 1'b1) begin bad++; $display("[TB] FAIL ldi_c1_ir_en: got %b want 1", irEn); end
    total++; if (pcAddr !== 4'h0) begin bad++; $display("[TB] FAIL ldi_c1_pc: got %h want 0", pcAddr); end
    tick();
    total++; if (irEn !== 1'b0) begin bad++; $display("[TB] FAIL ldi_c2_ir_en: got %b want 0", irEn); end
    total++; if (pcAddr !== 4'h1) begin bad++; $display("[TB] FAIL ldi_c2_pc: got %h want 1", pcAddr); end
    total++; if (operand !== 4'h0) begin bad++; $display("[TB] FAIL ldi_c2_operand: got %h want 0", operand); end
    tick();
    tick();
    total++; if (pcAddr !== 4'h2) begin bad++; $display("[TB] FAIL ldi_c4_pc: got %h want 2", pcAddr); end
    total++; if (irEn !== 1'b1) begin bad++; $display("[TB] FAIL ldi_c4_ir_en: got %b want 1", irEn); end
    for (int i = 0; i < 8; i++) tick();
    total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL alu_halted: got %b want 1", halted); end
    total++; if (pcAddr !== 4'h7) begin bad++; $display("[TB] FAIL alu_halt_pc: got %h want 7", pcAddr); end
    total++; if (obsQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL alu_strobe_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      strobe_t e = expQ.pop_front();
      strobe_t o = obsQ.pop_front();
      total++;
      if (o.cyc !== e.cyc || o.op !== e.op || o.opd !== e.opd) begin
        bad++;
        $display("[TB] FAIL alu_strobe: got cyc=%0d op=%b opd=%h want cyc=%0d op=%b opd=%h", o.cyc - base + 1, o.op, o.opd, e.cyc - base + 1, e.op, e.opd);
      end
    end
  endtask

  task automatic test_jumps();
    loadRom(64'h4C00_0000_0000_0000);
    run = 1'b1;
    doReset();
    tick(); tick(); tick();
    total++; if (pcAddr !== 4'hC) begin bad++; $display("[TB] FAIL jmp_pc: got %h want C", pcAddr); end
    total++; if (obsQ.size() !== 0) begin bad++; $display("[TB] FAIL jmp_no_acc: got %0d strobes want 0", obsQ.size()); end
    loadRom(64'h5900_0000_0000_0000);
    zeroFlag = 1'b1;
    doReset();
    tick(); tick(); tick();
    total++; if (pcAddr !== 4'h9) begin bad++; $display("[TB] FAIL jz_taken_pc: got %h want 9", pcAddr); end
    zeroFlag = 1'b0;
    doReset();
    tick(); tick(); tick();
    total++; if (pcAddr !== 4'h2) begin bad++; $display("[TB] FAIL jz_not_taken_pc: got %h want 2", pcAddr); end
  endtask

  task automatic test_wrap();
    // JMP F; ROM[F] = LDI whose immediate comes from address 0 after the wrap.
    loadRom(64'h4F00_0000_0000_0001);
    run = 1'b1;
    doReset();
    expQ.push_back('{base + 5, 2'b00, 4'h4});
    tick(); tick(); tick();
    total++; if (pcAddr !== 4'hF) begin bad++; $display("[TB] FAIL wrap_c4_pc: got %h want F", pcAddr); end
    tick();
    total++; if (pcAddr !== 4'h0) begin bad++; $display("[TB] FAIL wrap_c5_pc: got %h want 0", pcAddr); end
    tick(); tick();
    total++; if (pcAddr !== 4'h1) begin bad++; $display("[TB] FAIL wrap_c7_pc: got %h want 1", pcAddr); end
    total++; if (obsQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL wrap_strobe_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      strobe_t e = expQ.pop_front();
      strobe_t o = obsQ.pop_front();
      total++;
      if (o.cyc !== e.cyc || o.op !== e.op || o.opd !== e.opd) begin
        bad++;
        $display("[TB] FAIL wrap_strobe: got cyc=%0d op=%b opd=%h want cyc=%0d op=%b opd=%h", o.cyc - base + 1, o.op, o.opd, e.cyc - base + 1, e.op, e.opd);
      end
    end
    // Undefined opcode A behaves as a 2-cycle NOP.
    loadRom(64'hA170_0000_0000_0000);
    doReset();
    tick();
    total++; if (irEn !== 1'b0) begin bad++; $display("[TB] FAIL undef_c2_ir_en: got %b want 0", irEn); end
    tick();
    total++; if (irEn !== 1'b1) begin bad++; $display("[TB] FAIL undef_c3_ir_en: got %b want 1", irEn); end
    total++; if (pcAddr !== 4'h1) begin bad++; $display("[TB] FAIL undef_c3_pc: got %h want 1", pcAddr); end
    total++; if (obsQ.size() !== 0) begin bad++; $display("[TB] FAIL undef_no_acc: got %0d strobes want 0", obsQ.size()); end
  endtask

  task automatic test_stall();
    loadRom(64'h0000_0000_0000_0000);
    run = 1'b0;
    doReset();
    for (int i = 0; i < 3; i++) begin
      total++; if (irEn !== 1'b0) begin bad++; $display("[TB] FAIL stall_ir_en[%0d]: got %b want 0", i, irEn); end
      total++; if (pcAddr !== 4'h0) begin bad++; $display("[TB] FAIL stall_pc[%0d]: got %h want 0", i, pcAddr); end
      tick();
    end
    run = 1'b1;
    #1;
    total++; if (irEn !== 1'b1) begin bad++; $display("[TB] FAIL stall_release_ir_en: got %b want 1", irEn); end
    tick();
    total++; if (pcAddr !== 4'h1) begin bad++; $display("[TB] FAIL stall_release_pc: got %h want 1", pcAddr); end
  endtask

  task automatic test_halt();
    loadRom(64'hF000_0000_0000_0000);
    run = 1'b1;
    doReset();
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_held[%0d]: got %b want 1", i, halted); end
      total++; if (irEn !== 1'b0) begin bad++; $display("[TB] FAIL halt_ir_en[%0d]: got %b want 0", i, irEn); end
      total++; if (pcAddr !== 4'h1) begin bad++; $display("[TB] FAIL halt_pc[%0d]: got %h want 1", i, pcAddr); end
      tick();
    end
    doReset();
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_exit: got %b want 0", halted); end
    total++; if (pcAddr !== 4'h0) begin bad++; $display("[TB] FAIL halt_exit_pc: got %h want 0", pcAddr); end
  endtask

  task automatic test_reset_mid();
    loadRom(64'h2500_0000_0000_0000);
    run = 1'b1;
    doReset();
    tick();
    @(posedge clk);
    #1;
    regRst = 1'b1;
    #1;
    total++; if (accEn !== 1'b0) begin bad++; $display("[TB] FAIL midrst_acc_en: got %b want 0", accEn); end
    total++; if (operand !== 4'h0) begin bad++; $display("[TB] FAIL midrst_operand: got %h want 0", operand); end
    tick();
    tick();
    regRst = 1'b0;
    #1;
    total++; if (irEn !== 1'b1) begin bad++; $display("[TB] FAIL midrst_fetch_ir_en: got %b want 1", irEn); end
    total++; if (pcAddr !== 4'h0) begin bad++; $display("[TB] FAIL midrst_pc: got %h want 0", pcAddr); end
    total++; if (obsQ.size() !== 0) begin bad++; $display("[TB] FAIL midrst_no_strobe: got %0d strobes want 0", obsQ.size()); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jumps();
    test_wrap();
    test_stall();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
